// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line levels for the serial transmitter
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam logic IDLE_LVL = 1'b1;
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: byte handshake in, serial line and status out
interface serial_tx_if;
  logic [7:0] data;
  logic data_valid;
  logic data_ready;
  logic tx;
  logic busy;
  logic done;
  modport master (output data, data_valid, input data_ready, tx, busy, done);
  modport slave (input data, data_valid, output data_ready, tx, busy, done);
endinterface

// File: rtl/bit_timer.sv
// bit_timer: divides clk into bit periods, pulsing bit_end_o on the last cycle of each bit
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end_o = enable_i && cnt_q == LAST;
  // Count 0..CLKS_PER_BIT-1 while enabled, wrapping at each bit boundary
  always_comb cnt_d = clear_i ? '0 : !enable_i ? cnt_q : bit_end_o ? '0 : cnt_q + 1'b1;
  // Counter register
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: UART-style byte transmitter; define SERIAL_TX_PARITY_EN to add an even-parity bit
module serial_tx import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic clk,
  input logic reset,
  serial_tx_if.slave bus
);
  if (CLKS_PER_BIT < 2) begin : g_chk
    $error("serial_tx: CLKS_PER_BIT must be at least 2");
  end
  tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic hs, bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign hs = bus.data_valid && ready_q;
  assign bus.tx = tx_q;
  assign bus.data_ready = ready_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear_i(hs),
    .enable_i(state_q != IDLE),
    .bit_end_o(bit_end)
  );
  // State, datapath and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      tx_q <= IDLE_LVL;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  // Frame sequencing: latch on handshake, advance one state per bit period
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d = par_q;
`endif
    unique case (state_q)
      IDLE: if (hs) begin
        state_d = START;
        shift_d = bus.data;
        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
        par_d = ^bus.data;
`endif
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    tx_d = state_d == START ? START_LVL :
           state_d == DATA ? shift_d[0] :
`ifdef SERIAL_TX_PARITY_EN
           state_d == PARITY ? par_d :
`endif
           state_d == STOP ? STOP_LVL : IDLE_LVL;
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && state_d == IDLE;
  end
endmodule
